ram_port_arbiter: RTL

- Sequences the single SDRAM Wishbone slave port (sdram_top) between two masters.
- Master 1 is the HPS loader: ioctl word writes, throttled with ioctl_wait.
- Master 2 is the archimedes_top core bus: classic and incrementing-burst Wishbone.
- Replaces the combinational loader/core mux with a registered grant FSM: burst locking, a loader write buffer, download lockout and sticky error flags.

---
 rtl/ram_port_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - SDRAM Wishbone port arbiter between the HPS loader and the core bus
//
// Purpose: sequences the single SDRAM Wishbone slave port between the HPS
// loader (ioctl word writes, one-deep write buffer, throttled by ldr_wait) and
// the core Wishbone bus (classic and incrementing bursts). The grant is
// registered; a core grant is held for the whole of core_cyc, so bursts are
// never split and a pending loader write never preempts the core.
//
// Ports:
//   clk_sys, reset_n          system clock, asynchronous active-low reset
//   ram_ready                 SDRAM initialised; no grant is issued while low
//   ldr_active                download in progress; blocks new core grants
//   ldr_wr/addr/data/sel      loader write strobe, byte address, data, enables
//   ldr_wait                  loader throttle (high while the buffer is full)
//   core_cyc/stb/we/adr/sel/cti/dat_i, core_ack   core Wishbone master side
//   ram_cyc/stb/we/sel/cti/adr/dat_o, ram_ack     SDRAM Wishbone slave side
//   ldr_overrun               sticky: ldr_wr arrived while the buffer was full
//   bus_timeout               sticky watchdog flag (0 without the watchdog)
//
// Optional feature: define RAM_ARB_WATCHDOG_EN to abort a granted cycle after
// TIMEOUT cycles without ram_ack.

module ram_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ram_ready,
  input  logic              ldr_active,
  input  logic              ldr_wr,
  input  logic [24:0]       ldr_addr,
  input  logic [31:0]       ldr_data,
  input  logic [3:0]        ldr_sel,
  output logic              ldr_wait,
  input  logic              core_cyc,
  input  logic              core_stb,
  input  logic              core_we,
  input  logic [26:2]       core_adr,
  input  logic [3:0]        core_sel,
  input  logic [2:0]        core_cti,
  input  logic [31:0]       core_dat_i,
  output logic              core_ack,
  output logic              ram_cyc,
  output logic              ram_stb,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  output logic [2:0]        ram_cti,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [31:0]       ram_dat_o,
  input  logic              ram_ack,
  output logic              ldr_overrun,
  output logic              bus_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CORE = 2'd1,
    S_LDR  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_pend;
  logic [21:0] r_ldr_word;   // byte address bits [23:2]; higher bits wrap away
  logic [31:0] r_ldr_data;
  logic [3:0]  r_ldr_sel;
  logic        r_overrun;
  logic        w_grant;
  logic        w_pend_clr;

`ifdef RAM_ARB_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] r_wdog;
  logic            r_timeout;
  logic            w_wd_hit;
`endif

  // Address bits above 23 and the byte offset are intentionally discarded.
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, ldr_addr[24], ldr_addr[1:0], core_adr[26:24]};

  assign ldr_wait    = r_pend;
  assign ldr_overrun = r_overrun;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_pend_clr = 1'b0;
    core_ack   = 1'b0;
    ram_cyc    = 1'b0;
    ram_stb    = 1'b0;
    ram_we     = 1'b0;
    ram_sel    = 4'h0;
    ram_cti    = 3'b000;
    ram_adr    = '0;
    ram_dat_o  = 32'h0;
    case (r_state)
      S_IDLE: begin
        // Loader wins a tie; ram_ack is ignored here.
        if (ram_ready) begin
          if (r_pend) begin
            w_next  = S_LDR;
            w_grant = 1'b1;
          end else if (core_cyc && core_stb && !ldr_active) begin
            w_next  = S_CORE;
            w_grant = 1'b1;
          end
        end
      end
      S_LDR: begin
        ram_cyc   = 1'b1;
        ram_stb   = 1'b1;
        ram_we    = 1'b1;
        ram_sel   = r_ldr_sel;
        ram_adr   = ADDR_W'({r_ldr_word, 2'b00});
        ram_dat_o = r_ldr_data;
        if (ram_ack) begin
          w_next     = S_IDLE;
          w_pend_clr = 1'b1;
        end
      end
      S_CORE: begin
        // Held for the whole of core_cyc, including stb gaps inside a burst.
        ram_cyc   = core_cyc;
        ram_stb   = core_stb;
        ram_we    = core_we;
        ram_sel   = core_sel;
        ram_cti   = core_cti;
        ram_adr   = ADDR_W'({core_adr[23:2], 2'b00});
        ram_dat_o = core_dat_i;
        core_ack  = ram_ack;
        if (!core_cyc) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
`ifdef RAM_ARB_WATCHDOG_EN
    // Abort on the TIMEOUT-th cycle of ram_cyc without an ack; the core gets
    // a single fake ack so the CPU does not hang, a loader write is lost.
    w_wd_hit = ram_cyc && !ram_ack && (r_wdog == WD_W'(TIMEOUT - 1));
    if (w_wd_hit) begin
      w_next = S_IDLE;
      if (r_state == S_LDR) begin
        w_pend_clr = 1'b1;
      end
      if (r_state == S_CORE) begin
        core_ack = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= 1'b0;
      r_ldr_word <= 22'h0;
      r_ldr_data <= 32'h0;
      r_ldr_sel  <= 4'h0;
      r_overrun  <= 1'b0;
    end else begin
      // Clear only happens with pend=1 and capture only with pend=0.
      if (w_pend_clr) begin
        r_pend <= 1'b0;
      end
      if (ldr_wr && !r_pend) begin
        r_pend     <= 1'b1;
        r_ldr_word <= ldr_addr[23:2];
        r_ldr_data <= ldr_data;
        r_ldr_sel  <= ldr_sel;
      end
      if (ldr_wr && r_pend) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef RAM_ARB_WATCHDOG_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_grant || ram_ack) begin
        r_wdog <= '0;
      end else if (ram_cyc) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_wd_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign bus_timeout = r_timeout;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT != 0) && w_grant;
  assign bus_timeout  = 1'b0;
`endif

endmodule
